vdiv_seq: RTL

- Sequential IEEE-754 half-precision (FP16) divider; the inverse companion to the team's FP16 multiplier in the vector datapath.
- Accepts A and B on a start pulse and computes quotient = A / B.
- Uses a restoring radix-2 mantissa divider: one quotient bit per clock.
- Returns a rounded FP16 result with status flags and a one-cycle done pulse.

---
 rtl/fp16_pkg.sv | 21 ++
 rtl/fp16_round_pack.sv | 74 +++++++
 rtl/vdiv_seq.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// fp16_pkg: constants and types shared by the FP16 sequential datapath blocks.
// Holds the IEEE-754 half-precision field widths, the exponent bias, the
// largest normal biased exponent, the infinity magnitude pattern and the
// divider control state encoding.
package fp16_pkg;

    localparam int EXP_W   = 5;
    localparam int MAN_W   = 10;
    localparam int BIAS    = 15;
    localparam int EXP_MAX = 30;

    localparam logic [14:0] INF_MAG = 15'h7C00;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DIV,
        ROUND
    } state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// fp16_round_pack: combinational back end of the FP16 divider.
// Takes the raw restoring-division quotient and the final remainder. It
// normalises by one position when the integer bit is clear, rounds to nearest
// even, applies the exponent range checks and packs the FP16 result.
// Ports:
//   sign        result sign
//   exp_biased  signed biased exponent eA - eB + BIAS, before normalisation
//   q           14-bit quotient, bit 13 has weight 1
//   rem         final partial remainder; nonzero means inexact (sticky)
//   quotient    packed FP16 result
//   overflow    exponent above EXP_MAX; result is signed infinity
//   underflow   exponent below 1; result is signed zero
module fp16_round_pack
    import fp16_pkg::*;
(
    input  logic              sign,
    input  logic signed [7:0] exp_biased,
    input  logic [13:0]       q,
    input  logic [11:0]       rem,
    output logic [15:0]       quotient,
    output logic              overflow,
    output logic              underflow
);

    logic signed [7:0] exp_norm;
    logic signed [7:0] exp_final;
    logic [MAN_W-1:0]  man_trunc;
    logic [MAN_W-1:0]  man_final;
    logic [MAN_W:0]    man_sum;
    logic              guard;
    logic              sticky;
    logic              round_up;

    // The quotient of two normalised mantissas lies in (0.5, 2). When the
    // integer bit is clear the result is renormalised by taking the window
    // one bit lower and decrementing the exponent.
    always_comb begin
        exp_norm  = exp_biased;
        man_trunc = q[12:3];
        guard     = q[2];
        sticky    = (|q[1:0]) | (|rem);
        if (!q[13]) begin
            exp_norm  = exp_biased - 8'sd1;
            man_trunc = q[11:2];
            guard     = q[1];
            sticky    = q[0] | (|rem);
        end

        // Round to nearest, ties to even. A carry out of the mantissa
        // leaves a zero fraction and bumps the exponent.
        round_up  = guard & (sticky | man_trunc[0]);
        man_sum   = {1'b0, man_trunc} + {{MAN_W{1'b0}}, round_up};
        man_final = man_sum[MAN_W-1:0];
        exp_final = exp_norm;
        if (man_sum[MAN_W]) begin
            man_final = '0;
            exp_final = exp_norm + 8'sd1;
        end

        // The range checks run after rounding, so a carry can push a
        // result into overflow.
        overflow  = 1'b0;
        underflow = 1'b0;
        quotient  = {sign, exp_final[EXP_W-1:0], man_final};
        if (exp_final > $signed(8'(EXP_MAX))) begin
            overflow = 1'b1;
            quotient = {sign, INF_MAG};
        end else if (exp_final < 8'sd1) begin
            underflow = 1'b1;
            quotient  = {sign, 15'h0000};
        end
    end

endmodule

// File: rtl/vdiv_seq.sv
// vdiv_seq: sequential FP16 divider (quotient = A / B).
// The block normalises subnormal mantissas one bit per cycle. It then runs
// a restoring radix-2 divide, producing one quotient bit per cycle. It
// finishes with a single rounding/packing cycle. Zero operands skip the
// datapath and produce their fixed result directly. An exponent field of 31
// is treated as an ordinary finite value.
// Ports:
//   clk, rst    clock and synchronous active-high reset
//   start       request, sampled only while idle
//   A, B        FP16 dividend and divisor
//   busy        operation in flight
//   done        one-cycle pulse when quotient/flags are written
//   quotient    FP16 result, held until the next result
//   Overflow    result too large, quotient is signed infinity
//   Underflow   result too small, quotient is signed zero
//   DivByZero   divisor was +/-0
module vdiv_seq
    import fp16_pkg::*;
#(
    parameter int          QBITS   = 14,
    parameter logic [15:0] NAN_VAL = 16'h7E00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic        Overflow,
    output logic        Underflow,
    output logic        DivByZero
);

    state_t            state;
    logic              sign;
    logic [MAN_W:0]    man_a;
    logic [MAN_W:0]    man_b;
    logic signed [7:0] exp_a;
    logic signed [7:0] exp_b;
    logic [11:0]       rem;
    logic [13:0]       q;
    logic [3:0]        cnt;
    logic              special;
    logic              special_dbz;
    logic [15:0]       special_quot;

    logic              a_zero;
    logic              b_zero;
    logic              rem_ge;
    logic [10:0]       rem_diff;
    logic signed [7:0] exp_biased;
    logic [15:0]       rp_quot;
    logic              rp_ovf;
    logic              rp_unf;

    assign a_zero     = (A[14:0] == 15'h0000);
    assign b_zero     = (B[14:0] == 15'h0000);
    assign exp_biased = exp_a - exp_b + $signed(8'(BIAS));

    // A remainder of 2^11 or more always exceeds the divisor, so bit 11
    // is not needed on the keep path.
    assign rem_ge   = (rem >= {1'b0, man_b});
    assign rem_diff = rem_ge ? 11'(rem - {1'b0, man_b}) : rem[10:0];

    fp16_round_pack u_round_pack (
        .sign       (sign),
        .exp_biased (exp_biased),
        .q          (q),
        .rem        (rem),
        .quotient   (rp_quot),
        .overflow   (rp_ovf),
        .underflow  (rp_unf)
    );

    // Control FSM and datapath registers. A zero exponent field decodes to
    // effective exponent 1 with a clear hidden bit. NORM then shifts that
    // mantissa up, decrementing its exponent, until bit 10 is set. Outputs
    // are written only on the ROUND exit edge, so they hold between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            quotient     <= '0;
            Overflow     <= 1'b0;
            Underflow    <= 1'b0;
            DivByZero    <= 1'b0;
            sign         <= 1'b0;
            man_a        <= '0;
            man_b        <= '0;
            exp_a        <= '0;
            exp_b        <= '0;
            rem          <= '0;
            q            <= '0;
            cnt          <= '0;
            special      <= 1'b0;
            special_dbz  <= 1'b0;
            special_quot <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy        <= 1'b1;
                        sign        <= A[15] ^ B[15];
                        man_a       <= {|A[14:10], A[9:0]};
                        man_b       <= {|B[14:10], B[9:0]};
                        exp_a       <= (A[14:10] == 5'd0) ? 8'sd1 : $signed({3'b000, A[14:10]});
                        exp_b       <= (B[14:10] == 5'd0) ? 8'sd1 : $signed({3'b000, B[14:10]});
                        special     <= a_zero | b_zero;
                        special_dbz <= b_zero;
                        if (b_zero) begin
                            special_quot <= a_zero ? NAN_VAL : {A[15] ^ B[15], INF_MAG};
                        end else begin
                            special_quot <= {A[15] ^ B[15], 15'h0000};
                        end
                        state <= (a_zero | b_zero) ? ROUND : NORM;
                    end
                end
                NORM: begin
                    if (man_a[MAN_W] && man_b[MAN_W]) begin
                        rem   <= {1'b0, man_a};
                        q     <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end else begin
                        if (!man_a[MAN_W]) begin
                            man_a <= man_a << 1;
                            exp_a <= exp_a - 8'sd1;
                        end
                        if (!man_b[MAN_W]) begin
                            man_b <= man_b << 1;
                            exp_b <= exp_b - 8'sd1;
                        end
                    end
                end
                DIV: begin
                    q   <= {q[12:0], rem_ge};
                    rem <= {rem_diff, 1'b0};
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(QBITS - 1)) begin
                        state <= ROUND;
                    end
                end
                ROUND: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                    if (special) begin
                        quotient  <= special_quot;
                        Overflow  <= 1'b0;
                        Underflow <= 1'b0;
                        DivByZero <= special_dbz;
                    end else begin
                        quotient  <= rp_quot;
                        Overflow  <= rp_ovf;
                        Underflow <= rp_unf;
                        DivByZero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
